uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 16: number of byte entries; SHALL be a power of two, at least 2.
REQ-002 Parameter DATA_W, default 8: entry width, equal to the UART byte width.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  reset; synchronous and active-high.
REQ-005 i_Rx_Done  input  1  one-cycle strobe from the UART receiver: the byte is valid.
REQ-006 i_Rx_Byte  input  DATA_W  received byte, sampled only when i_Rx_Done=1.
REQ-007 o_Data  output  DATA_W  head-of-queue byte.
REQ-008 o_Valid  output  1  the queue is non-empty and o_Data is valid.
REQ-009 i_Ready  input  1  consumer accepts o_Data.
REQ-010 o_Count  output  $clog2(DEPTH)+1  current occupancy, range 0..DEPTH.
REQ-011 o_Full  output  1  o_Count==DEPTH.
REQ-012 o_Empty  output  1  o_Count==0.
REQ-013 o_Overflow  output  1  sticky flag: at least one byte was dropped.
REQ-014 i_Clr_Overflow  input  1  one-cycle clear of o_Overflow.

Function
REQ-015 Push: i_Rx_Done=1 with the push accepted SHALL write i_Rx_Byte at the write pointer and advance the write pointer by 1, modulo DEPTH.
REQ-016 Pop: o_Valid=1 and i_Ready=1 in the same cycle SHALL advance the read pointer by 1, modulo DEPTH.
REQ-017 The read side SHALL be first-word-fall-through: o_Data SHALL equal the head entry combinationally from registered state whenever o_Valid=1.
REQ-018 o_Data SHALL be 8'h00 when o_Valid=0.
REQ-019 Push-to-o_Valid latency SHALL be exactly 1 cycle; there is no same-cycle bypass when empty.
REQ-020 A push SHALL be accepted when o_Full=0, or when o_Full=1 and a pop occurs in the same cycle.
REQ-021 A push that is not accepted SHALL drop the byte, leave pointers and o_Count unchanged, and set o_Overflow on the next cycle.
REQ-022 o_Count SHALL increment on push only, decrement on pop only, and hold on a simultaneous push and pop.
REQ-023 A push and pop on the same cycle when o_Count==1 SHALL leave o_Valid=1 with the new byte at the head on the next cycle.
REQ-024 Pops SHALL not occur when empty: i_Ready while o_Valid=0 SHALL be ignored.
REQ-025 i_Clr_Overflow=1 SHALL clear o_Overflow on the next cycle; if a drop occurs in the same cycle, the set SHALL win.
REQ-026 Pointer wrap from DEPTH-1 to 0 SHALL be seamless, with no lost or duplicated entry.
REQ-027 Byte order at o_Data SHALL equal i_Rx_Done arrival order.

Reset
REQ-028 On reset=1 at a rising clk edge, the pointers, o_Count and o_Overflow SHALL go to 0, giving o_Empty=1, o_Full=0, o_Valid=0 and o_Data=8'h00.
REQ-029 Reset mid-operation SHALL discard all stored bytes, and an i_Rx_Done in the reset cycle SHALL be ignored.
REQ-030 Storage array contents SHALL not require reset.

Structure
REQ-031 Package uart_pkg SHALL hold UART_DATA_W=8 and UART_RX_FIFO_DEPTH=16, shared with the UART receiver.
REQ-032 Storage SHALL be one sub-module, uart_fifo_mem: a DEPTH x DATA_W register array with one write port and one asynchronous read port.
REQ-033 Pointers SHALL be $clog2(DEPTH) bits wide, and occupancy SHALL be tracked by the o_Count register.

Verification
REQ-034 After reset, push 0xA5 then 0x3C with i_Ready=0 -> o_Count=2, o_Data=0xA5; then raise i_Ready -> 0xA5 then 0x3C are popped, then o_Empty=1 and o_Data=0x00.
REQ-035 With i_Ready=0, push 17 bytes 0x00..0x10 -> o_Full=1 after 16; 0x10 is dropped and o_Overflow=1; draining yields 0x00..0x0F.
REQ-036 When full, push 0x77 and pop in the same cycle -> o_Count stays 16, o_Overflow stays 0, and 0x77 is the last byte drained.
REQ-037 Stream 40 bytes with i_Ready=1 continuously -> pointers wrap twice, the output order matches the input order, and o_Count never exceeds 1.
REQ-038 Assert i_Clr_Overflow in the same cycle as a dropped push -> o_Overflow=1; a later clear alone -> o_Overflow=0.
REQ-039 Push 5 bytes, then assert reset for 1 cycle together with i_Rx_Done -> o_Count=0, o_Valid=0, and no byte is retained.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants used by the receiver and its byte FIFO.
package uart_pkg;

    localparam int UART_DATA_W        = 8;
    localparam int UART_RX_FIFO_DEPTH = 16;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_W register array: one clocked write port, one asynchronous read port.
module uart_fifo_mem #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are deliberately left unreset; occupancy tracking masks stale entries.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte queue between the UART receiver and its consumer,
// with a sticky overflow flag for bytes dropped while full.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = UART_RX_FIFO_DEPTH,
    parameter int DATA_W = UART_DATA_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_Rx_Done,
    input  logic [DATA_W-1:0]          i_Rx_Byte,
    output logic [DATA_W-1:0]          o_Data,
    output logic                       o_Valid,
    input  logic                       i_Ready,
    output logic [$clog2(DEPTH):0]     o_Count,
    output logic                       o_Full,
    output logic                       o_Empty,
    output logic                       o_Overflow,
    input  logic                       i_Clr_Overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              overflow;
    logic [DATA_W-1:0] rd_data;
    logic              pop;
    logic              push_ok;
    logic              drop;

    // A full queue can still take a byte when the consumer frees a slot this cycle.
    assign pop     = o_Valid && i_Ready;
    assign push_ok = i_Rx_Done && (!o_Full || pop);
    assign drop    = i_Rx_Done && !push_ok;

    uart_fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push_ok && !reset),
        .wr_addr (wr_ptr),
        .wr_data (i_Rx_Byte),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop) begin
                overflow <= 1'b1;
            end else if (i_Clr_Overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    assign o_Count    = count;
    assign o_Full     = (count == CW'(DEPTH));
    assign o_Empty    = (count == '0);
    assign o_Valid    = !o_Empty;
    assign o_Overflow = overflow;
    assign o_Data     = o_Valid ? rd_data : '0;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo with hand-computed expectations.
module tb_uart_rx_fifo;

    localparam int DEPTH  = 16;
    localparam int DATA_W = 8;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              i_Rx_Done = 1'b0;
    logic [DATA_W-1:0] i_Rx_Byte = '0;
    logic [DATA_W-1:0] o_Data;
    logic              o_Valid;
    logic              i_Ready = 1'b0;
    logic [CW-1:0]     o_Count;
    logic              o_Full;
    logic              o_Empty;
    logic              o_Overflow;
    logic              i_Clr_Overflow = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_Rx_Done      (i_Rx_Done),
        .i_Rx_Byte      (i_Rx_Byte),
        .o_Data         (o_Data),
        .o_Valid        (o_Valid),
        .i_Ready        (i_Ready),
        .o_Count        (o_Count),
        .o_Full         (o_Full),
        .o_Empty        (o_Empty),
        .o_Overflow     (o_Overflow),
        .i_Clr_Overflow (i_Clr_Overflow)
    );

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        i_Rx_Done = 1'b0;
        i_Ready = 1'b0;
        i_Clr_Overflow = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic push_bytes(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            i_Rx_Done = 1'b1;
            i_Rx_Byte = first + 8'(i);
            step();
        end
        i_Rx_Done = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (o_Count !== 5'd0) begin errors++; $display("[TB] FAIL reset_count got=%0d exp=0", o_Count); end
        checks++; if (o_Empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty got=%b exp=1", o_Empty); end
        checks++; if (o_Full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full got=%b exp=0", o_Full); end
        checks++; if (o_Valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%b exp=0", o_Valid); end
        checks++; if (o_Data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data got=%02h exp=00", o_Data); end
        checks++; if (o_Overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf got=%b exp=0", o_Overflow); end
    endtask

    task automatic test_basic();
        do_reset();
        i_Rx_Done = 1'b1;
        i_Rx_Byte = 8'hA5;
        #1;
        checks++; if (o_Valid !== 1'b0) begin errors++; $display("[TB] FAIL no_bypass got=%b exp=0", o_Valid); end
        step();
        checks++; if (o_Valid !== 1'b1 || o_Data !== 8'hA5) begin errors++; $display("[TB] FAIL latency1 valid=%b data=%02h exp 1/A5", o_Valid, o_Data); end
        i_Rx_Byte = 8'h3C;
        step();
        i_Rx_Done = 1'b0;
        checks++; if (o_Count !== 5'd2) begin errors++; $display("[TB] FAIL basic_count got=%0d exp=2", o_Count); end
        checks++; if (o_Data !== 8'hA5) begin errors++; $display("[TB] FAIL basic_head got=%02h exp=A5", o_Data); end
        i_Ready = 1'b1;
        step();
        checks++; if (o_Data !== 8'h3C || o_Count !== 5'd1) begin errors++; $display("[TB] FAIL basic_pop1 data=%02h cnt=%0d exp 3C/1", o_Data, o_Count); end
        step();
        checks++; if (o_Empty !== 1'b1 || o_Data !== 8'h00) begin errors++; $display("[TB] FAIL basic_empty empty=%b data=%02h exp 1/00", o_Empty, o_Data); end
        step();
        checks++; if (o_Count !== 5'd0) begin errors++; $display("[TB] FAIL pop_when_empty cnt=%0d exp=0", o_Count); end
        i_Ready = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset();
        push_bytes(8'h00, 16);
        checks++; if (o_Full !== 1'b1 || o_Count !== 5'd16) begin errors++; $display("[TB] FAIL fill_full full=%b cnt=%0d exp 1/16", o_Full, o_Count); end
        checks++; if (o_Overflow !== 1'b0) begin errors++; $display("[TB] FAIL fill_ovf got=%b exp=0", o_Overflow); end
        push_bytes(8'h10, 1);
        checks++; if (o_Overflow !== 1'b1 || o_Count !== 5'd16) begin errors++; $display("[TB] FAIL drop ovf=%b cnt=%0d exp 1/16", o_Overflow, o_Count); end
        i_Ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++; if (o_Data !== 8'(i)) begin errors++; $display("[TB] FAIL drain[%0d] got=%02h exp=%02h", i, o_Data, 8'(i)); end
            step();
        end
        checks++; if (o_Empty !== 1'b1) begin errors++; $display("[TB] FAIL drain_empty got=%b exp=1", o_Empty); end
        i_Ready = 1'b0;
    endtask

    task automatic test_full_push_pop();
        do_reset();
        push_bytes(8'h00, 16);
        i_Rx_Done = 1'b1;
        i_Rx_Byte = 8'h77;
        i_Ready = 1'b1;
        step();
        i_Rx_Done = 1'b0;
        i_Ready = 1'b0;
        checks++; if (o_Count !== 5'd16 || o_Overflow !== 1'b0) begin errors++; $display("[TB] FAIL full_pp cnt=%0d ovf=%b exp 16/0", o_Count, o_Overflow); end
        i_Ready = 1'b1;
        for (int i = 1; i < 16; i++) begin
            checks++; if (o_Data !== 8'(i)) begin errors++; $display("[TB] FAIL full_pp_drain[%0d] got=%02h exp=%02h", i, o_Data, 8'(i)); end
            step();
        end
        checks++; if (o_Data !== 8'h77 || o_Count !== 5'd1) begin errors++; $display("[TB] FAIL full_pp_last data=%02h cnt=%0d exp 77/1", o_Data, o_Count); end
        step();
        i_Ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        i_Ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            i_Rx_Done = 1'b1;
            i_Rx_Byte = 8'h40 + 8'(i);
            step();
            checks++; if (o_Data !== 8'h40 + 8'(i) || o_Count !== 5'd1) begin errors++; $display("[TB] FAIL stream[%0d] data=%02h cnt=%0d exp %02h/1", i, o_Data, o_Count, 8'h40 + 8'(i)); end
        end
        i_Rx_Done = 1'b0;
        step();
        checks++; if (o_Empty !== 1'b1) begin errors++; $display("[TB] FAIL stream_end empty=%b exp=1", o_Empty); end
        i_Ready = 1'b0;
    endtask

    task automatic test_clr_overflow();
        do_reset();
        push_bytes(8'h20, 16);
        i_Rx_Done = 1'b1;
        i_Rx_Byte = 8'hFF;
        i_Clr_Overflow = 1'b1;
        step();
        i_Rx_Done = 1'b0;
        checks++; if (o_Overflow !== 1'b1) begin errors++; $display("[TB] FAIL set_wins got=%b exp=1", o_Overflow); end
        step();
        i_Clr_Overflow = 1'b0;
        checks++; if (o_Overflow !== 1'b0) begin errors++; $display("[TB] FAIL clear got=%b exp=0", o_Overflow); end
        checks++; if (o_Data !== 8'h20) begin errors++; $display("[TB] FAIL clr_head got=%02h exp=20", o_Data); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        push_bytes(8'h01, 5);
        checks++; if (o_Count !== 5'd5) begin errors++; $display("[TB] FAIL pre_reset cnt=%0d exp=5", o_Count); end
        reset = 1'b1;
        i_Rx_Done = 1'b1;
        i_Rx_Byte = 8'hEE;
        step();
        reset = 1'b0;
        i_Rx_Done = 1'b0;
        checks++; if (o_Count !== 5'd0 || o_Valid !== 1'b0 || o_Data !== 8'h00) begin errors++; $display("[TB] FAIL mid_reset cnt=%0d valid=%b data=%02h exp 0/0/00", o_Count, o_Valid, o_Data); end
        step();
        checks++; if (o_Valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_hold valid=%b exp=0", o_Valid); end
        push_bytes(8'h5A, 1);
        checks++; if (o_Data !== 8'h5A || o_Count !== 5'd1) begin errors++; $display("[TB] FAIL after_reset data=%02h cnt=%0d exp 5A/1", o_Data, o_Count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_clr_overflow();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
